mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Pipeline stage directly downstream of the execute stage. Latches execute results, performs the
//  load/store on a req/ack data-memory port, and hands the write-back record to the WB stage.
//  Stalls execute via ex_ready while a memory access is outstanding. Non-memory ops pass through.
// PARAMETERS
//  DATA_W      32   data / address width
//  REG_ADDR_W  5    register-file address width
//  TIMEOUT     255  max cycles waiting for dmem_ack before bus error (8-bit counter, 1..255)
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           async reset, active-low
//  ex_valid       in   1           execute result valid this cycle
//  ex_ready       out  1           stage can accept; transfer when ex_valid & ex_ready
//  ex_alu_result  in   DATA_W      ALU result; memory address for ld/st
//  ex_store_data  in   DATA_W      rs2 value for stores
//  ex_rd          in   REG_ADDR_W  destination register
//  ex_reg_we      in   1           register write enable
//  ex_data_we     in   1           store (1) / not store (0)
//  ex_reg_select  in   1           1 = load (WB data from memory), 0 = ALU result
//  ex_funct3      in   3           size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  dmem_req       out  1           memory request, held until ack
//  dmem_we        out  1           write request
//  dmem_addr      out  DATA_W      word-aligned address (addr[1:0] = 0)
//  dmem_wdata     out  DATA_W      store data replicated into lanes
//  dmem_be        out  4           byte enables
//  dmem_ack       in   1           access complete; rdata valid same cycle for reads
//  dmem_rdata     in   DATA_W      read word
//  wb_valid       out  1           write-back record valid (one-cycle pulse per op)
//  wb_rd          out  REG_ADDR_W  destination register
//  wb_reg_we      out  1           register write enable (forced 0 on error)
//  wb_data        out  DATA_W      ALU result or extended load data
//  bus_err        out  1           one-cycle pulse: ack timeout (or misalign, see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all outputs 0 except ex_ready=1; timeout counter 0.
//  FSM IDLE: ex_ready=1. On transfer: non-mem op -> wb record next cycle, stay IDLE.
//    load/store -> latch fields, go REQ; dmem_req=1 from the next cycle.
//  REQ: ex_ready=0; dmem_* held stable. Counter increments each cycle without ack.
//    dmem_ack -> go IDLE; next cycle wb_valid=1 (load: extended data, store: wb_reg_we=0).
//    counter reaches TIMEOUT without ack -> drop req, bus_err=1 & wb_valid=1 with wb_reg_we=0, IDLE.
//  Ack arriving while dmem_req=0 is ignored. Ack in the same cycle as timeout: ack wins.
//  Latency: non-mem 1 cycle; mem = ack cycle + 1. Back-to-back non-mem ops at 1/cycle.
//  Byte lanes: B/BU be=0001<<a[1:0]; H/HU be=0011<<a[1:0]; W be=1111. Store data replicated
//   (byte x4, half x2). Load: select lane by a[1:0], sign-extend (B,H) or zero-extend (BU,HU).
//  Unsupported funct3 (011,110,111): treated as W.
//  wb_rd = 0 forces wb_reg_we=0. Mid-access reset: req drops immediately, no WB record issued.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: H with a[0]=1 or W with a[1:0]!=0 -> no dmem_req; next cycle
//   wb_valid=1, wb_reg_we=0, bus_err=1. Undefined: offending low address bits forced to 0
//   (H aligned to halfword, W to word) and access proceeds; bus_err only on timeout.
// TESTING
//  ALU op rd=5, result 0x1234 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, no dmem_req.
//  SW addr 0x100 data 0xDEADBEEF, ack after 3 cycles -> be=1111, ex_ready=0 for 3+1 cycles, wb_reg_we=0.
//  LB addr 0x103, rdata 0x80FFFFFF -> be=1000, wb_data=0xFFFFFF80; LBU -> 0x00000080.
//  SH addr 0x102 data 0x0000ABCD -> be=1100, wdata=0xABCDABCD; LH read 0x8001xxxx -> 0xFFFF8001.
//  Load, no ack for TIMEOUT=255 cycles -> req drops, bus_err pulse, wb_valid with wb_reg_we=0.
//  LW addr 0x101: with MEM_MISALIGN_TRAP_EN -> no req, bus_err=1; without -> dmem_addr=0x100.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master(output req, we, addr, wdata, be, input ack, rdata);
    modport slave(input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: latches EX results, runs load/store on the dmem req/ack bus, emits one WB record per op.
// MEM_MISALIGN_TRAP_EN: misaligned H/W accesses raise bus_err instead of being force-aligned.
module mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_we,
    input  logic                  ex_data_we,
    input  logic                  ex_reg_select,
    input  logic [2:0]            ex_funct3,
    mem_stage_if.master           dmem,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_we,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  bus_err
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_nx;
    logic xfer, is_mem, is_h, is_w, trap, done, timeout;
    logic [1:0] off, off_q;
    logic [2:0] f3_q;
    logic [7:0] cnt;
    logic [REG_ADDR_W-1:0] rd_q;
    logic reg_we_q;
    logic [DATA_W-1:0] alu_q, sh, ld;

    assign xfer    = ex_valid && state == IDLE;
    assign is_mem  = ex_data_we || ex_reg_select;
    assign is_h    = ex_funct3[1:0] == 2'b01;
    // funct3 x10/x11 (W and the unsupported codes) are all word-sized
    assign is_w    = ex_funct3[1];
    assign off     = is_w ? 2'b00 : is_h ? {ex_alu_result[1], 1'b0} : ex_alu_result[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap    = is_mem && ((is_h && ex_alu_result[0]) || (is_w && ex_alu_result[1:0] != 2'b00));
`else
    assign trap    = 1'b0;
`endif
    assign done    = state == REQ && dmem.ack;
    assign timeout = state == REQ && !dmem.ack && cnt == 8'(TIMEOUT - 1);
    assign sh      = dmem.rdata >> {off_q, 3'b000};
    assign ld      = f3_q[1] ? sh :
                     f3_q[0] ? {{(DATA_W-16){!f3_q[2] && sh[15]}}, sh[15:0]} :
                               {{(DATA_W-8){!f3_q[2] && sh[7]}}, sh[7:0]};

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx = state;
        ex_ready = state == IDLE;
        dmem.req = state == REQ;
        if (xfer && is_mem && !trap) state_nx = REQ;
        if (done || timeout) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt        <= '0;
            off_q      <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            reg_we_q   <= 1'b0;
            alu_q      <= '0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            dmem.be    <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_reg_we  <= 1'b0;
            wb_data    <= '0;
            bus_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            bus_err  <= 1'b0;
            cnt      <= (state == REQ && !done && !timeout) ? cnt + 8'd1 : 8'd0;
            if (xfer && (!is_mem || trap)) begin
                wb_valid  <= 1'b1;
                wb_rd     <= ex_rd;
                wb_reg_we <= !is_mem && ex_reg_we && ex_rd != '0;
                wb_data   <= ex_alu_result;
                bus_err   <= trap;
            end else if (xfer) begin
                off_q      <= off;
                f3_q       <= ex_funct3;
                rd_q       <= ex_rd;
                reg_we_q   <= ex_reg_we && !ex_data_we && ex_rd != '0;
                alu_q      <= ex_alu_result;
                dmem.we    <= ex_data_we;
                dmem.addr  <= {ex_alu_result[DATA_W-1:2], 2'b00};
                dmem.wdata <= is_w ? ex_store_data : is_h ? {2{ex_store_data[15:0]}} : {4{ex_store_data[7:0]}};
                dmem.be    <= is_w ? 4'b1111 : is_h ? 4'b0011 << off : 4'b0001 << off;
            end
            if (done || timeout) begin
                wb_valid  <= 1'b1;
                wb_rd     <= rd_q;
                wb_reg_we <= done && reg_we_q;
                wb_data   <= (done && !dmem.we) ? ld : alu_q;
                bus_err   <= timeout;
            end
        end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed mem_stage tests scored against a behavioural byte-lane / extension model.
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int TO = 255;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic        rwe;
        logic [31:0] data;
        logic        err;
        logic        dchk;
    } wb_t;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
    } acc_t;

    logic clk = 1'b0, rst = 1'b1;
    logic ex_valid = 1'b0, ex_reg_we = 1'b0, ex_data_we = 1'b0, ex_reg_select = 1'b0;
    logic [31:0] ex_alu_result = '0, ex_store_data = '0;
    logic [4:0] ex_rd = '0;
    logic [2:0] ex_funct3 = '0;
    logic ex_ready, wb_valid, wb_reg_we, bus_err;
    logic [4:0] wb_rd;
    logic [31:0] wb_data;

    mem_stage_if #(.DATA_W(32)) mif();

    mem_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_data_we(ex_data_we), .ex_reg_select(ex_reg_select),
        .ex_funct3(ex_funct3), .dmem(mif), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_reg_we(wb_reg_we), .wb_data(wb_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    wb_t q[$];
    wb_t ce;
    acc_t cur;
    bit cur_on = 1'b0, spur = 1'b0;
    int ack_after = 0, rn = 0;
    logic [31:0] rdata_v = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Memory answers on the ack_after-th request cycle (0 = never)
    always @(negedge clk) begin
        rn = mif.req ? rn + 1 : 0;
        mif.ack = spur || (mif.req && ack_after != 0 && rn == ack_after);
        mif.rdata = rdata_v;
    end

    always @(negedge clk) if (rst) begin
        if (wb_valid) begin
            if (q.size() == 0) chk("wb_spurious", 32'(wb_valid), 32'd0);
            else begin
                ce = q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(ce.rd));
                chk("wb_reg_we", 32'(wb_reg_we), 32'(ce.rwe));
                chk("wb_bus_err", 32'(bus_err), 32'(ce.err));
                if (ce.dchk) chk("wb_data", wb_data, ce.data);
            end
        end else chk("bus_err_idle", 32'(bus_err), 32'd0);
        if (mif.req) begin
            if (!cur_on) chk("req_spurious", 32'(mif.req), 32'd0);
            else begin
                chk("dmem_we", 32'(mif.we), 32'(cur.we));
                chk("dmem_addr", mif.addr, cur.addr);
                chk("dmem_be", 32'(mif.be), 32'(cur.be));
                if (cur.we) chk("dmem_wdata", mif.wdata, cur.wd);
            end
        end
    end

    task automatic model(input logic [2:0] f3, input logic we, sel, input logic [4:0] rd, input logic rwe,
                         input logic [31:0] a, sd, rw, output wb_t w, output acc_t c, output bit mem, output bit trap);
        int s, lane;
        logic [31:0] ae;
        logic [63:0] v;
        s = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mem = we || sel;
        trap = TRAP && mem && (a % 32'(s) != 0);
        ae = a - (a % 32'(s));
        lane = int'(ae % 4);
        c.we = we;
        c.addr = a & 32'hFFFF_FFFC;
        c.be = (s == 4) ? 4'hF : 4'(((1 << s) - 1) << lane);
        c.wd = (s == 1) ? 32'(sd[7:0]) * 32'h0101_0101 : (s == 2) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
        v = (64'(rw) >> (8 * lane)) & ((64'd1 << (8 * s)) - 64'd1);
        if (s < 4 && !f3[2] && v[8*s-1]) v = v - (64'd1 << (8 * s));
        w.rd = rd;
        w.err = trap;
        w.rwe = rwe && rd != 5'd0 && !we && !trap;
        w.dchk = !we && !trap;
        w.data = mem ? v[31:0] : a;
    endtask

    task automatic drive(input logic [2:0] f3, input logic we, sel, input logic [4:0] rd, input logic rwe,
                         input logic [31:0] a, sd);
        ex_funct3 = f3; ex_data_we = we; ex_reg_select = sel; ex_rd = rd;
        ex_reg_we = rwe; ex_alu_result = a; ex_store_data = sd; ex_valid = 1'b1;
    endtask

    task automatic do_op(input logic [2:0] f3, input logic we, sel, input logic [4:0] rd, input logic rwe,
                         input logic [31:0] a, sd, rw, input int ack_n,
                         output logic [3:0] g_be, output logic [31:0] g_addr, g_wd, g_data, output logic g_err);
        wb_t w;
        acc_t c;
        bit mem, trap;
        int n, exp_n;
        model(f3, we, sel, rd, rwe, a, sd, rw, w, c, mem, trap);
        if (mem && !trap && ack_n == 0) begin w.err = 1'b1; w.rwe = 1'b0; w.dchk = 1'b0; end
        exp_n = (mem && !trap) ? (ack_n == 0 ? TO : ack_n) : 0;
        chk("ready_before", 32'(ex_ready), 32'd1);
        ack_after = ack_n;
        rdata_v = rw;
        cur = c;
        cur_on = mem && !trap;
        q.push_back(w);
        drive(f3, we, sel, rd, rwe, a, sd);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        n = 0;
        g_be = '0; g_addr = '0; g_wd = '0;
        while (!ex_ready && n < TO + 40) begin
            if (n == 0) begin g_be = mif.be; g_addr = mif.addr; g_wd = mif.wdata; end
            n++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", 32'(n), 32'(exp_n));
        chk("wb_latency", 32'(wb_valid), 32'd1);
        g_data = wb_data;
        g_err = bus_err;
        cur_on = 1'b0;
    endtask

    initial begin
        logic [3:0] be;
        logic [31:0] ad, wd, dt;
        logic er;
        wb_t w;
        acc_t c;
        bit mem, trap;
        #2 rst = 1'b0;
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_req", 32'(mif.req), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_be", 32'(mif.be), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        do_op(3'b010, 0, 0, 5'd5, 1, 32'h1234, 0, 0, 0, be, ad, wd, dt, er);
        chk("alu_data", dt, 32'h1234);
        do_op(3'b010, 1, 0, 5'd0, 0, 32'h100, 32'hDEAD_BEEF, 0, 4, be, ad, wd, dt, er);
        chk("sw_be", 32'(be), 32'hF);
        chk("sw_wdata", wd, 32'hDEAD_BEEF);
        chk("sw_addr", ad, 32'h100);
        do_op(3'b000, 0, 1, 5'd7, 1, 32'h103, 0, 32'h80FF_FFFF, 1, be, ad, wd, dt, er);
        chk("lb_be", 32'(be), 32'b1000);
        chk("lb_data", dt, 32'hFFFF_FF80);
        do_op(3'b100, 0, 1, 5'd7, 1, 32'h103, 0, 32'h80FF_FFFF, 2, be, ad, wd, dt, er);
        chk("lbu_data", dt, 32'h0000_0080);
        do_op(3'b001, 1, 0, 5'd0, 0, 32'h102, 32'h0000_ABCD, 0, 3, be, ad, wd, dt, er);
        chk("sh_be", 32'(be), 32'b1100);
        chk("sh_wdata", wd, 32'hABCD_ABCD);
        do_op(3'b001, 0, 1, 5'd9, 1, 32'h102, 0, 32'h8001_1234, 2, be, ad, wd, dt, er);
        chk("lh_data", dt, 32'hFFFF_8001);
        do_op(3'b101, 0, 1, 5'd9, 1, 32'h100, 0, 32'h1234_F00F, 2, be, ad, wd, dt, er);
        chk("lhu_data", dt, 32'h0000_F00F);
        do_op(3'b111, 0, 1, 5'd3, 1, 32'h200, 0, 32'hCAFE_F00D, 1, be, ad, wd, dt, er);
        chk("f3_111_be", 32'(be), 32'hF);
        chk("f3_111_data", dt, 32'hCAFE_F00D);
        do_op(3'b010, 0, 1, 5'd0, 1, 32'h10, 0, 32'h5555_AAAA, 2, be, ad, wd, dt, er);

        for (int i = 0; i < 3; i++) begin
            model(3'b010, 0, 0, 5'(i + 1), 1, 32'(32'h100 + i), 0, 0, w, c, mem, trap);
            q.push_back(w);
            drive(3'b010, 0, 0, 5'(i + 1), 1, 32'(32'h100 + i), 0);
            @(posedge clk); #1;
            chk("b2b_ready", 32'(ex_ready), 32'd1);
            chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
            chk("b2b_data", wb_data, 32'(32'h100 + i));
        end
        ex_valid = 1'b0;

        spur = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("spur_ready", 32'(ex_ready), 32'd1);
            chk("spur_req", 32'(mif.req), 32'd0);
        end
        spur = 1'b0;
        @(posedge clk); #1;

        do_op(3'b010, 0, 1, 5'd4, 1, 32'h101, 0, 32'h1122_3344, 1, be, ad, wd, dt, er);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lw_mis_err", 32'(er), 32'd1);
`else
        chk("lw_mis_addr", ad, 32'h100);
        chk("lw_mis_data", dt, 32'h1122_3344);
`endif
        do_op(3'b010, 0, 1, 5'd6, 1, 32'h400, 0, 32'h0, 0, be, ad, wd, dt, er);
        chk("timeout_err", 32'(er), 32'd1);
        do_op(3'b010, 0, 1, 5'd6, 1, 32'h404, 0, 32'h7777_0001, TO, be, ad, wd, dt, er);
        chk("ack_at_limit_err", 32'(er), 32'd0);
        chk("ack_at_limit_data", dt, 32'h7777_0001);

        model(3'b010, 0, 1, 5'd8, 1, 32'h300, 0, 0, w, c, mem, trap);
        cur = c;
        cur_on = 1'b1;
        ack_after = 0;
        drive(3'b010, 0, 1, 5'd8, 1, 32'h300, 0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_req_high", 32'(mif.req), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_req_drop", 32'(mif.req), 32'd0);
        chk("mid_ready", 32'(ex_ready), 32'd1);
        cur_on = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_no_wb", 32'(wb_valid), 32'd0);
        end

        do_op(3'b010, 0, 0, 5'd12, 1, 32'hABCD, 0, 0, 0, be, ad, wd, dt, er);
        chk("post_rst_data", dt, 32'hABCD);
        @(posedge clk); #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
